// File: rtl/instbuffer_pkg.sv
// Shared encodings for the instruction buffer: issue modes, occupancy codes, bus width.
// Latency: n/a (constants and a pure helper function).
// Backpressure: n/a.
package instbuffer_pkg;

  // Issue mode returned by the issue stage: how many entries it consumed this cycle.
  localparam logic [1:0] NO_ISSUE     = 2'b00;
  localparam logic [1:0] SINGLE_ISSUE = 2'b01;
  localparam logic [1:0] DOUBLE_ISSUE = 2'b10;

  // Saturated occupancy code presented to issue.
  localparam logic [1:0] HAVE_NO_INST  = 2'b00;
  localparam logic [1:0] HAVE_ONE_INST = 2'b01;
  localparam logic [1:0] HAVE_TWO_INST = 2'b10;

  // [130:96] pc/exception info, [95:0] decode payload.
  localparam int INST_BUS_W = 131;

  // Number of entries issue asks to retire; the reserved code 2'b11 retires nothing.
  function automatic logic [1:0] issue_to_npop(input logic [1:0] mode);
    logic [1:0] n;
    n = 2'd0;
    case (mode)
      NO_ISSUE:     n = 2'd0;
      SINGLE_ISSUE: n = 2'd1;
      DOUBLE_ISSUE: n = 2'd2;
      default:      n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/instbuffer_ibuf_mem.sv
// Instruction storage (ibuf_mem): DEPTH x BUS_W flops, writes at addr and addr+1, two async reads.
// Latency: write visible on the read ports after the writing edge; reads are combinational.
// Backpressure: none; the caller decides when to write. Contents are never reset.
module instbuffer_ibuf_mem
  import instbuffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int BUS_W = INST_BUS_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we1,
  input  logic             we2,
  input  logic [AW-1:0]    waddr,
  input  logic [BUS_W-1:0] wdat1,
  input  logic [BUS_W-1:0] wdat2,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [BUS_W-1:0] rdat1,
  output logic [BUS_W-1:0] rdat2
);

  logic [BUS_W-1:0] mem [DEPTH];

  // Slot 2 always lands one entry after slot 1; the AW-bit add wraps at DEPTH-1 -> 0.
  always_ff @(posedge clk) begin
    if (we1) mem[waddr] <= wdat1;
    if (we2) mem[waddr + AW'(1)] <= wdat2;
  end

  assign rdat1 = mem[raddr1];
  assign rdat2 = mem[raddr2];

endmodule

// File: rtl/instbuffer.sv
// Dual-port instruction FIFO between fetch and issue: 0/1/2 in, 0/1/2 out per cycle, flushable.
// Latency: an entry pushed at edge N appears on inst1/inst2 after edge N (no bypass).
// Backpressure: ibuf_allowin_o drops when fewer than two slots are free; fetch slots offered then are lost.
module instbuffer
  import instbuffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int BUS_W = INST_BUS_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [1:0]                issue_mode_i,
  input  logic                      fetch_valid1_i,
  input  logic                      fetch_valid2_i,
  input  logic [BUS_W-1:0]          fetch_inst1_bus_i,
  input  logic [BUS_W-1:0]          fetch_inst2_bus_i,
  output logic                      ibuf_allowin_o,
  output logic [1:0]                instbuffer_count_o,
  output logic [BUS_W-1:0]          inst1_bus_o,
  output logic [BUS_W-1:0]          inst2_bus_o,
  output logic [$clog2(DEPTH):0]    used_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;
  localparam logic [UW-1:0] ALLOWIN_MAX = UW'(DEPTH - 2);

  logic [AW-1:0]    head, tail, head_next, tail_next;
  logic [UW-1:0]    used, used_next;
  logic [1:0]       npush, req_pop, npop;
  logic             push_ok, we1, we2;
  logic [BUS_W-1:0] rdat1, rdat2;

  // Room for two is judged on registered occupancy only, so a same-cycle pop never widens it.
  assign ibuf_allowin_o = (used <= ALLOWIN_MAX);

  // Slot 2 without slot 1 is malformed fetch output and is treated as an empty cycle.
  assign push_ok = ibuf_allowin_o && fetch_valid1_i && !flush_i;
  assign we1     = push_ok;
  assign we2     = push_ok && fetch_valid2_i;
  assign req_pop = issue_to_npop(issue_mode_i);

  // Work out push/pop counts and the next pointer/occupancy values; flush empties everything.
  always_comb begin
    npush     = 2'd0;
    npop      = 2'd0;
    head_next = head;
    tail_next = tail;
    used_next = used;
    if (flush_i) begin
      head_next = '0;
      tail_next = '0;
      used_next = '0;
    end else begin
      if (we2)      npush = 2'd2;
      else if (we1) npush = 2'd1;
      // Over-retiring is clamped; when it happens used < 2 so its low bits are the true count.
      if (UW'(req_pop) > used) npop = used[1:0];
      else                     npop = req_pop;
      head_next = head + AW'(npop);
      tail_next = tail + AW'(npush);
      used_next = used + UW'(npush) - UW'(npop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      used <= '0;
    end else begin
      head <= head_next;
      tail <= tail_next;
      used <= used_next;
    end
  end

  // Protocol checks on the neighbouring stages; the buffer itself stays consistent either way.
  always_ff @(posedge clk) begin
    if (rst && !flush_i) begin
      assert (UW'(req_pop) <= used)
        else $warning("instbuffer: issue retired %0d entries with only %0d held, clamped", req_pop, used);
      assert (issue_mode_i != 2'b11)
        else $warning("instbuffer: reserved issue mode 2'b11 seen");
      assert (!(fetch_valid2_i && !fetch_valid1_i))
        else $warning("instbuffer: fetch slot 2 valid without slot 1, ignored");
    end
  end

  instbuffer_ibuf_mem #(
    .DEPTH (DEPTH),
    .BUS_W (BUS_W),
    .AW    (AW)
  ) u_ibuf_mem (
    .clk    (clk),
    .we1    (we1),
    .we2    (we2),
    .waddr  (tail),
    .wdat1  (fetch_inst1_bus_i),
    .wdat2  (fetch_inst2_bus_i),
    .raddr1 (head),
    .raddr2 (head + AW'(1)),
    .rdat1  (rdat1),
    .rdat2  (rdat2)
  );

  // Outputs come purely from registered state; stale memory is masked by occupancy.
  always_comb begin
    instbuffer_count_o = HAVE_TWO_INST;
    if (used == '0)          instbuffer_count_o = HAVE_NO_INST;
    else if (used == UW'(1)) instbuffer_count_o = HAVE_ONE_INST;
    inst1_bus_o = (used >= UW'(1)) ? rdat1 : '0;
    inst2_bus_o = (used >= UW'(2)) ? rdat2 : '0;
  end

  assign used_o = used;

endmodule
